// File: rtl/axi4lite_regbank.sv
// AXI4-Lite register bank: N_RW read/write registers (reg 0 bits in PULSE_MASK self-clear) plus N_RO read-only inputs.
// Macro AXI4LITE_REGBANK_SLVERR_EN: SLVERR for unmapped accesses and RO writes; without it every response is OKAY.
module axi4lite_regbank #(
  parameter int          N_RW       = 8,
  parameter int          N_RO       = 2,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] PULSE_MASK = 32'h0000_0001,
  localparam int         RO_W       = (N_RO > 0) ? N_RO : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [32*N_RW-1:0]   rw_regs,
  input  logic [32*RO_W-1:0]   ro_regs,
  output logic [N_RW-1:0]      wr_pulse,
  output logic [RO_W-1:0]      rd_pulse
);

  localparam int IW = ADDR_W - 2;
  localparam int XW = IW + 1;
  localparam logic [XW-1:0] RW_END = XW'(N_RW);
  localparam logic [XW-1:0] RO_END = XW'(N_RW + N_RO);
`ifdef AXI4LITE_REGBANK_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic [N_RW-1:0][31:0] regs;
  logic                  aw_full;
  logic                  w_full;
  logic [IW-1:0]         aw_idx;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic [IW-1:0]         ar_idx;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  aw_is_rw;
  logic                  ar_is_rw;
  logic                  ar_is_ro;
  logic [31:0]           wmask;
  logic [31:0]           reg0_base;
  logic [31:0]           rd_val;
  logic                  unused_addr_bits;

  // Readies are gated by resetn so they read low while reset is held.
  assign s_axi_awready = resetn & ~aw_full & ~s_axi_bvalid;
  assign s_axi_wready  = resetn & ~w_full & ~s_axi_bvalid;
  assign s_axi_arready = resetn & ~s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_full & w_full & ~s_axi_bvalid;

  assign ar_idx   = s_axi_araddr[ADDR_W-1:2];
  assign aw_is_rw = ({1'b0, aw_idx} < RW_END);
  assign ar_is_rw = ({1'b0, ar_idx} < RW_END);
  assign ar_is_ro = ~ar_is_rw & ({1'b0, ar_idx} < RO_END);

  assign wmask     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign reg0_base = regs[0] & ~PULSE_MASK;
  assign rw_regs   = regs;

  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_RW; i++)
      if (ar_idx == IW'(i)) rd_val = regs[i];
    for (int j = 0; j < N_RO; j++)
      if ({1'b0, ar_idx} == XW'(N_RW + j)) rd_val = ro_regs[32*j +: 32];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs         <= '0;
      aw_full      <= 1'b0;
      aw_idx       <= '0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      wr_pulse     <= '0;
      rd_pulse     <= '0;
    end else begin
      wr_pulse <= '0;
      rd_pulse <= '0;
      // Pulse bits can only be set by the previous cycle's commit, so clearing every cycle gives a one-cycle high.
      regs[0]  <= reg0_base;

      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end

      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= aw_is_rw ? 2'b00 : ERR_RESP;
        for (int i = 0; i < N_RW; i++) begin
          if (aw_idx == IW'(i)) begin
            regs[i]     <= (((i == 0) ? reg0_base : regs[i]) & ~wmask) | (w_data & wmask);
            wr_pulse[i] <= 1'b1;
          end
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
        s_axi_rresp  <= (ar_is_rw | ar_is_ro) ? 2'b00 : ERR_RESP;
        for (int j = 0; j < N_RO; j++)
          if ({1'b0, ar_idx} == XW'(N_RW + j)) rd_pulse[j] <= 1'b1;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Bench for axi4lite_regbank: directed scenarios plus randomized traffic checked against an array-based register model.
module tb_axi4lite_regbank;
  localparam int N_RW = 8;
  localparam int N_RO = 2;
  localparam int ADDR_W = 8;
  localparam logic [31:0] PMASK = 32'h0000_0001;
`ifdef AXI4LITE_REGBANK_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic s_axi_awvalid = 1'b0;
  logic s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_wvalid = 1'b0;
  logic s_axi_wready;
  logic [1:0] s_axi_bresp;
  logic s_axi_bvalid;
  logic s_axi_bready = 1'b0;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic s_axi_arvalid = 1'b0;
  logic s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic s_axi_rvalid;
  logic s_axi_rready = 1'b0;
  logic [32*N_RW-1:0] rw_regs;
  logic [32*N_RO-1:0] ro_regs;
  logic [N_RW-1:0] wr_pulse;
  logic [N_RO-1:0] rd_pulse;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] model_rw [N_RW];
  logic [31:0] ro_val [N_RO];

  always #5 clk = ~clk;
  assign ro_regs = {ro_val[1], ro_val[0]};

  axi4lite_regbank #(.N_RW(N_RW), .N_RO(N_RO), .ADDR_W(ADDR_W), .PULSE_MASK(PMASK)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rw_regs(rw_regs), .ro_regs(ro_regs), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  function automatic logic [32*N_RW-1:0] model_vec();
    logic [32*N_RW-1:0] v;
    for (int i = 0; i < N_RW; i++) v[32*i +: 32] = model_rw[i];
    return v;
  endfunction

  function automatic void model_write(int idx, logic [31:0] data, logic [3:0] strb);
    if (idx < N_RW)
      for (int k = 0; k < 4; k++)
        if (strb[k]) model_rw[idx][8*k +: 8] = data[8*k +: 8];
  endfunction

  function automatic logic [31:0] model_read(int idx);
    if (idx < N_RW) return model_rw[idx];
    if (idx < N_RW + N_RO) return ro_val[idx - N_RW];
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(bit mapped_ok);
    return (SLV && !mapped_ok) ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_RW; i++) model_rw[i] = 32'h0;
  endfunction

  // lead > 0: W handshakes lead cycles before AW; lead < 0: AW leads; returns just after bvalid is first seen.
  task automatic send_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, output bit seen, output int cyc);
    bit aw_done, w_done, aw_hs, w_hs;
    int cnt;
    aw_done = 0; w_done = 0; cnt = 0; seen = 0; cyc = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = (lead <= 0); s_axi_wvalid = (lead >= 0);
    while (cyc < 40 && !seen) begin
      aw_hs = s_axi_awvalid & s_axi_awready;
      w_hs = s_axi_wvalid & s_axi_wready;
      @(posedge clk); #1; cyc++;
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin s_axi_wvalid = 1'b0; w_done = 1; end
      if (lead > 0 && w_done && !aw_done && !s_axi_awvalid) begin
        if (cnt == lead - 1) s_axi_awvalid = 1'b1; else cnt++;
      end
      if (lead < 0 && aw_done && !w_done && !s_axi_wvalid) begin
        if (cnt == -lead - 1) s_axi_wvalid = 1'b1; else cnt++;
      end
      if (s_axi_bvalid) seen = 1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic send_read(input logic [7:0] addr, output bit seen, output int cyc);
    bit hs;
    seen = 0; cyc = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (cyc < 20 && !seen) begin
      hs = s_axi_arvalid & s_axi_arready;
      @(posedge clk); #1; cyc++;
      if (hs) s_axi_arvalid = 1'b0;
      if (s_axi_rvalid) seen = 1;
    end
    s_axi_arvalid = 1'b0;
  endtask

  task automatic complete_b();
    s_axi_bready = 1'b1; @(posedge clk); #1; s_axi_bready = 1'b0;
  endtask

  task automatic complete_r();
    s_axi_rready = 1'b1; @(posedge clk); #1; s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    n_tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin n_fail++; $display("FAIL reset_readies: got %b want 000", {s_axi_awready, s_axi_wready, s_axi_arready}); end
    n_tests++; if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids: got %b want 00", {s_axi_bvalid, s_axi_rvalid}); end
    n_tests++; if ({s_axi_rdata, s_axi_bresp, s_axi_rresp} !== 36'h0) begin n_fail++; $display("FAIL reset_data_resp: got %h want 0", {s_axi_rdata, s_axi_bresp, s_axi_rresp}); end
    n_tests++; if ({wr_pulse, rd_pulse} !== '0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0", {wr_pulse, rd_pulse}); end
    n_tests++; if (rw_regs !== model_vec()) begin n_fail++; $display("FAIL reset_regs: got %h want %h", rw_regs, model_vec()); end
    resetn = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin n_fail++; $display("FAIL idle_readies: got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
  endtask

  task automatic test_write_basic();
    bit seen; int cyc;
    s_axi_bready = 1'b1;
    send_write(8'h04, 32'hDEADBEEF, 4'hF, 0, seen, cyc);
    model_write(1, 32'hDEADBEEF, 4'hF);
    n_tests++; if (!seen || cyc != 2) begin n_fail++; $display("FAIL basic_b_latency: got seen=%0d cycles=%0d want 1/2", seen, cyc); end
    n_tests++; if (rw_regs !== model_vec()) begin n_fail++; $display("FAIL basic_regs: got %h want %h", rw_regs, model_vec()); end
    n_tests++; if (wr_pulse !== 8'b0000_0010) begin n_fail++; $display("FAIL basic_wr_pulse: got %b want 00000010", wr_pulse); end
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    n_tests++; if ({s_axi_bvalid, wr_pulse} !== 9'h0) begin n_fail++; $display("FAIL basic_after_b: got bvalid=%b wr_pulse=%b want 0/0", s_axi_bvalid, wr_pulse); end
  endtask

  task automatic test_w_before_aw();
    bit seen; int cyc;
    send_write(8'h08, 32'h11223344, 4'b0101, 3, seen, cyc);
    model_write(2, 32'h11223344, 4'b0101);
    n_tests++; if (!seen || cyc != 5) begin n_fail++; $display("FAIL wfirst_latency: got seen=%0d cycles=%0d want 1/5", seen, cyc); end
    n_tests++; if (rw_regs[95:64] !== 32'h00220044) begin n_fail++; $display("FAIL wfirst_reg2: got %h want 00220044", rw_regs[95:64]); end
    n_tests++; if (rw_regs !== model_vec()) begin n_fail++; $display("FAIL wfirst_regs: got %h want %h", rw_regs, model_vec()); end
    complete_b();
    n_tests++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL wfirst_bclear: got %b want 0", s_axi_bvalid); end
  endtask

  task automatic test_pulse();
    bit seen; int cyc;
    send_write(8'h00, 32'h00000003, 4'hF, 0, seen, cyc);
    model_write(0, 32'h00000003, 4'hF);
    n_tests++; if (!seen || rw_regs[31:0] !== 32'h3) begin n_fail++; $display("FAIL pulse_high: got seen=%0d reg0=%h want 1/00000003", seen, rw_regs[31:0]); end
    complete_b();
    model_rw[0] = model_rw[0] & ~PMASK;
    n_tests++; if (rw_regs[31:0] !== 32'h2) begin n_fail++; $display("FAIL pulse_cleared: got %h want 00000002", rw_regs[31:0]); end
  endtask

  task automatic test_ro_read();
    bit seen; int cyc;
    ro_val[0] = 32'hCAFEF00D; ro_val[1] = $urandom;
    send_read(8'h20, seen, cyc);
    n_tests++; if (!seen || cyc != 1) begin n_fail++; $display("FAIL ro_latency: got seen=%0d cycles=%0d want 1/1", seen, cyc); end
    n_tests++; if (s_axi_rdata !== 32'hCAFEF00D || s_axi_rresp !== 2'b00) begin n_fail++; $display("FAIL ro_data: got %h/%b want cafef00d/00", s_axi_rdata, s_axi_rresp); end
    n_tests++; if (rd_pulse !== 2'b01) begin n_fail++; $display("FAIL ro_rd_pulse: got %b want 01", rd_pulse); end
    ro_val[0] = 32'h13572468;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hCAFEF00D || s_axi_arready !== 1'b0 || rd_pulse !== 2'b00) begin
        n_fail++; $display("FAIL ro_hold c%0d: got rvalid=%b rdata=%h arready=%b rd_pulse=%b want 1/cafef00d/0/00", c, s_axi_rvalid, s_axi_rdata, s_axi_arready, rd_pulse);
      end
    end
    complete_r();
    n_tests++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL ro_rclear: got %b want 0", s_axi_rvalid); end
  endtask

  task automatic test_unmapped();
    bit seen; int cyc;
    send_read(8'h3C, seen, cyc);
    n_tests++; if (!seen || s_axi_rdata !== 32'h0 || s_axi_rresp !== exp_resp(0)) begin n_fail++; $display("FAIL unmapped_read: got seen=%0d rdata=%h rresp=%b want 1/0/%b", seen, s_axi_rdata, s_axi_rresp, exp_resp(0)); end
    n_tests++; if (rd_pulse !== 2'b00) begin n_fail++; $display("FAIL unmapped_rd_pulse: got %b want 00", rd_pulse); end
    complete_r();
    send_write(8'h24, 32'hA5A5_5A5A, 4'hF, 0, seen, cyc);
    n_tests++; if (!seen || s_axi_bresp !== exp_resp(0)) begin n_fail++; $display("FAIL ro_write_resp: got seen=%0d bresp=%b want 1/%b", seen, s_axi_bresp, exp_resp(0)); end
    n_tests++; if (wr_pulse !== '0 || rw_regs !== model_vec()) begin n_fail++; $display("FAIL ro_write_effect: got wr_pulse=%b regs=%h want 0/%h", wr_pulse, rw_regs, model_vec()); end
    complete_b();
  endtask

  task automatic test_concurrent();
    bit seen; int cyc;
    send_write(8'h14, 32'h0BADF00D, 4'hF, 0, seen, cyc);
    model_write(5, 32'h0BADF00D, 4'hF);
    complete_b();
    s_axi_awaddr = 8'h14; s_axi_wdata = 32'h600DCAFE; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 8'h14; s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n_tests++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== model_read(5)) begin n_fail++; $display("FAIL same_edge_read: got rvalid=%b rdata=%h want 1/%h", s_axi_rvalid, s_axi_rdata, model_read(5)); end
    model_write(5, 32'h600DCAFE, 4'hF);
    n_tests++; if (s_axi_bvalid !== 1'b1 || rw_regs !== model_vec()) begin n_fail++; $display("FAIL same_edge_write: got bvalid=%b regs=%h want 1/%h", s_axi_bvalid, rw_regs, model_vec()); end
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    n_tests++; if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin n_fail++; $display("FAIL same_edge_clear: got %b want 00", {s_axi_bvalid, s_axi_rvalid}); end
  endtask

  task automatic test_reset_mid();
    s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    n_tests++; if (s_axi_awready !== 1'b0) begin n_fail++; $display("FAIL mid_aw_held: got awready=%b want 0", s_axi_awready); end
    resetn = 1'b0; #1;
    model_reset();
    n_tests++; if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b want 00000", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}); end
    n_tests++; if (rw_regs !== model_vec() || {wr_pulse, rd_pulse, s_axi_rdata} !== '0) begin n_fail++; $display("FAIL mid_reset_data: got regs=%h rdata=%h want 0/0", rw_regs, s_axi_rdata); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    s_axi_wdata = 32'h5A5A5A5A; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_tests++; if (s_axi_bvalid !== 1'b0 || rw_regs !== model_vec()) begin n_fail++; $display("FAIL mid_no_commit c%0d: got bvalid=%b regs=%h want 0/%h", c, s_axi_bvalid, rw_regs, model_vec()); end
    end
    n_tests++; if ({s_axi_awready, s_axi_wready} !== 2'b10) begin n_fail++; $display("FAIL mid_w_held: got aw/w ready=%b want 10", {s_axi_awready, s_axi_wready}); end
    s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    @(posedge clk); #1;
    model_write(3, 32'h5A5A5A5A, 4'hF);
    n_tests++; if (s_axi_bvalid !== 1'b1 || rw_regs !== model_vec()) begin n_fail++; $display("FAIL mid_new_aw: got bvalid=%b regs=%h want 1/%h", s_axi_bvalid, rw_regs, model_vec()); end
    complete_b();
  endtask

  task automatic test_random();
    bit seen; int cyc, idx, hold;
    logic [7:0] addr; logic [31:0] data, exp_rd; logic [3:0] strb;
    logic [N_RW-1:0] exp_wp; logic [N_RO-1:0] exp_rp;
    for (int it = 0; it < 80; it++) begin
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 11));
      addr = {6'(idx), 2'($urandom_range(0, 3))};
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom; strb = 4'($urandom_range(0, 15));
        send_write(addr, data, strb, int'($urandom_range(0, 6)) - 3, seen, cyc);
        model_write(idx, data, strb);
        exp_wp = (idx < N_RW) ? N_RW'(1 << idx) : '0;
        n_tests++; if (!seen || s_axi_bresp !== exp_resp(idx < N_RW)) begin n_fail++; $display("FAIL rnd_wr_resp it%0d idx%0d: got seen=%0d bresp=%b want 1/%b", it, idx, seen, s_axi_bresp, exp_resp(idx < N_RW)); end
        n_tests++; if (rw_regs !== model_vec()) begin n_fail++; $display("FAIL rnd_wr_regs it%0d idx%0d: got %h want %h", it, idx, rw_regs, model_vec()); end
        if (strb != 4'h0) begin
          n_tests++; if (wr_pulse !== exp_wp) begin n_fail++; $display("FAIL rnd_wr_pulse it%0d: got %b want %b", it, wr_pulse, exp_wp); end
        end
        model_rw[0] = model_rw[0] & ~PMASK;
        for (int c = 0; c < hold; c++) begin
          @(posedge clk); #1;
          n_tests++; if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) begin n_fail++; $display("FAIL rnd_b_hold it%0d: got bvalid=%b awready=%b want 1/0", it, s_axi_bvalid, s_axi_awready); end
        end
        complete_b();
        n_tests++; if (s_axi_bvalid !== 1'b0 || rw_regs !== model_vec()) begin n_fail++; $display("FAIL rnd_wr_after it%0d: got bvalid=%b regs=%h want 0/%h", it, s_axi_bvalid, rw_regs, model_vec()); end
      end else begin
        ro_val[0] = $urandom; ro_val[1] = $urandom;
        exp_rd = model_read(idx);
        exp_rp = (idx >= N_RW && idx < N_RW + N_RO) ? N_RO'(1 << (idx - N_RW)) : '0;
        send_read(addr, seen, cyc);
        n_tests++; if (!seen || s_axi_rdata !== exp_rd || s_axi_rresp !== exp_resp(idx < N_RW + N_RO)) begin n_fail++; $display("FAIL rnd_rd it%0d idx%0d: got seen=%0d rdata=%h rresp=%b want 1/%h/%b", it, idx, seen, s_axi_rdata, s_axi_rresp, exp_rd, exp_resp(idx < N_RW + N_RO)); end
        n_tests++; if (rd_pulse !== exp_rp) begin n_fail++; $display("FAIL rnd_rd_pulse it%0d: got %b want %b", it, rd_pulse, exp_rp); end
        for (int c = 0; c < hold; c++) begin
          ro_val[0] = $urandom; ro_val[1] = $urandom;
          @(posedge clk); #1;
          n_tests++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_r_hold it%0d: got rvalid=%b rdata=%h want 1/%h", it, s_axi_rvalid, s_axi_rdata, exp_rd); end
        end
        complete_r();
        n_tests++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rnd_rclear it%0d: got %b want 0", it, s_axi_rvalid); end
      end
    end
  endtask

  initial begin
    ro_val[0] = 32'h0; ro_val[1] = 32'h0;
    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_pulse();
    test_ro_read();
    test_unmapped();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4lite_regbank.md
AXI4LITE_REGBANK -- requirements
Module: axi4lite_regbank

Interface
REQ-001 SHALL have parameter N_RW, default 8, meaning number of read/write registers (range 1..16).
REQ-002 SHALL have parameter N_RO, default 2, meaning number of read-only registers (range 0..16).
REQ-003 SHALL have parameter ADDR_W, default 8, meaning significant byte-address bits (6..16); N_RW+N_RO SHALL be at most 2^(ADDR_W-2).
REQ-004 SHALL have parameter PULSE_MASK, default 32'h0000_0001, meaning bits of RW register 0 that self-clear.
REQ-005 SHALL have these ports, one per line:
- clk  in  1  clock, all logic rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- s_axi_awaddr  in  ADDR_W  write byte address.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata  in  32; s_axi_wstrb  in  4; s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_W; s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1.
- rw_regs  out  32*N_RW  flattened RW registers, register i at [32i+31:32i].
- ro_regs  in  32*N_RO  flattened RO inputs, same packing.
- wr_pulse  out  N_RW  one-cycle strobe per RW register written.
- rd_pulse  out  max(N_RO,1)  one-cycle strobe per RO register read (clear-on-read hook).

Function
REQ-006 SHALL decode index = addr[ADDR_W-1:2] and ignore addr[1:0]: RW register i at index i, RO register j at index N_RW+j, all other indices unmapped.
REQ-007 SHALL accept AW and W independently into one-entry holding buffers; awready = AW buffer empty AND bvalid low; wready = W buffer empty AND bvalid low.
REQ-008 SHALL commit the write on the first edge where both buffers are full and bvalid is low. At that edge: update the register, clear both buffers, set bvalid.
REQ-009 SHALL update byte k of the target RW register only when wstrb[k]=1; wstrb=0 SHALL change no register but still complete with a response.
REQ-010 SHALL make the new register value and bvalid visible in the same cycle, asserting wr_pulse[i] for exactly that cycle.
REQ-011 SHALL hold bvalid and bresp stable until bready; bvalid SHALL clear on the edge where bvalid and bready are both high.
REQ-012 SHALL assert arready = NOT rvalid. On an AR handshake it SHALL register rdata/rresp, set rvalid on the next edge, and assert rd_pulse[j] for that one cycle when a RO register is addressed.
REQ-013 SHALL hold rvalid, rdata and rresp stable until rready; rvalid SHALL clear on the edge where rvalid and rready are both high.
REQ-014 SHALL return 32'h0 in rdata for unmapped reads.
REQ-015 SHALL treat writes to RO or unmapped indices as no-ops that still produce a response, with no wr_pulse.
REQ-016 SHALL clear each bit of RW register 0 selected by PULSE_MASK one cycle after it is written to 1, so it reads 1 for exactly one cycle. A concurrent rewrite of 1 SHALL keep it high for one more cycle.
REQ-017 SHALL run the read and write channels concurrently. A read of a register committed on the same edge SHALL return the pre-write value.

Reset
REQ-018 SHALL, while resetn is low, force the following to zero: all RW registers, both holding buffers, awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp, wr_pulse and rd_pulse.
REQ-019 SHALL abandon any partial or pending transaction on reset mid-operation, with no register update after resetn deasserts.

Configuration
REQ-020 SHALL, with macro AXI4LITE_REGBANK_SLVERR_EN defined, return bresp/rresp = 2'b10 (SLVERR) for unmapped accesses and for writes to RO indices, and 2'b00 otherwise.
REQ-021 SHALL, without AXI4LITE_REGBANK_SLVERR_EN, return 2'b00 (OKAY) for every response; the register side effects SHALL be identical in both builds.

Verification
REQ-022 SHALL check: AW addr 0x04 and W 0xDEADBEEF/strb 4'hF in the same cycle, bready=1 -> rw reg1 = 0xDEADBEEF and bvalid one cycle after the handshake; wr_pulse[1] for one cycle.
REQ-023 SHALL check: W before AW by 3 cycles, addr 0x08, wstrb 4'b0101, data 0x11223344 over an old value of 0 -> reg2 = 0x00220044.
REQ-024 SHALL check: write 0x00000003 to 0x00 with PULSE_MASK=1 -> reg0 reads 0x3 for one cycle, then 0x2.
REQ-025 SHALL check: ro_regs j=0 = 0xCAFEF00D, read at 0x20 (N_RW=8) -> rdata 0xCAFEF00D, rd_pulse[0]=1 for one cycle. With rready held low for 5 cycles, rvalid and rdata SHALL stay stable and arready SHALL stay low.
REQ-026 SHALL check: read at 0x3C and write at 0x24 -> rdata 0 with rresp 2'b10 when AXI4LITE_REGBANK_SLVERR_EN is defined, 2'b00 when it is not; no RW register changes.
REQ-027 SHALL check: resetn pulsed low after the AW handshake but before W -> all outputs 0. A W arriving after resetn deasserts SHALL be held until a new AW arrives.
